ppu_vram_port: RTL and testbench

// - CPU-side PPUDATA/PPUADDR access port driving the 2 KB nametable VRAM (initiator end of the VRAM en/rw/addr/data interface).
// - Holds the 14-bit PPU address, the two-write address latch, the +1/+32 increment and the one-deep PPUDATA read buffer.
// - Sits between the CPU register decode and the nametable VRAM. Only nametable-range accesses reach VRAM.

---
 rtl/ppu_vram_pkg.sv | 30 +++
 rtl/ppu_vram_port_nt_mirror.sv | 34 +++
 rtl/ppu_vram_port.sv | 159 +++++++++++++++
 tb/tb_ppu_vram_port.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vram_pkg.sv
// Shared types and constants for the PPU VRAM access port.
// Build option: define PPU_VRAM_MIRROR_EN to add the mirror_h input and
// selectable horizontal/vertical nametable mirroring.
package ppu_vram_pkg;

    localparam int PPU_AW  = 14;
    localparam int VRAM_AW = 11;

    // Inclusive bounds of the nametable window in PPU address space.
    localparam logic [PPU_AW-1:0] NT_LO = 14'h2000;
    localparam logic [PPU_AW-1:0] NT_HI = 14'h3EFF;

    typedef enum logic [1:0] {
        SEL_CTRL   = 2'd0,
        SEL_STATUS = 2'd1,
        SEL_ADDR   = 2'd2,
        SEL_DATA   = 2'd3
    } sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    function automatic logic in_nametable(input logic [PPU_AW-1:0] a);
        return (a >= NT_LO) && (a <= NT_HI);
    endfunction

endpackage

// File: rtl/ppu_vram_port_nt_mirror.sv
// Combinational PPU address -> 2 KB VRAM address mapping.
// Build option: PPU_VRAM_MIRROR_EN adds mirror_h (1 = horizontal mirroring);
// without it the vertical mapping addr[10:0] is fixed.
module nt_mirror
    import ppu_vram_pkg::*;
(
    input  logic [PPU_AW-1:0]  ppu_addr,
`ifdef PPU_VRAM_MIRROR_EN
    input  logic               mirror_h,
`endif
    output logic [VRAM_AW-1:0] vram_addr
);

`ifdef PPU_VRAM_MIRROR_EN
    // Upper bits only select the nametable window, which the caller decodes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ppu_addr[13:12];

    // Horizontal mirroring folds nametables by addr[11], vertical by addr[10].
    always_comb begin
        if (mirror_h) vram_addr = {ppu_addr[11], ppu_addr[9:0]};
        else          vram_addr = ppu_addr[10:0];
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^ppu_addr[13:11];

    // Fixed vertical mirroring.
    always_comb begin
        vram_addr = ppu_addr[10:0];
    end
`endif

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-side PPUCTRL/PPUSTATUS/PPUADDR/PPUDATA access port into nametable VRAM.
// Holds the PPU address, two-write address latch, +1/+32 increment and the
// one-deep PPUDATA read buffer. Build option: PPU_VRAM_MIRROR_EN adds mirror_h.
module ppu_vram_port
    import ppu_vram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_rw,
    input  logic [1:0]         cpu_sel,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic               cpu_ack,
    output logic               busy,
`ifdef PPU_VRAM_MIRROR_EN
    input  logic               mirror_h,
`endif
    output logic               vram_en,
    output logic               vram_rw,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_din,
    input  logic [7:0]         vram_dout
);

    state_t              state, state_nxt;
    logic [PPU_AW-1:0]   addr;
    logic [PPU_AW-1:0]   addr_inc;
    logic                w;
    logic                inc32;
    logic [7:0]          rd_buf;

    // Request captured at acceptance, consumed in ACCESS.
    sel_t                req_sel;
    logic                req_rw;
    logic [7:0]          req_din;

    logic                nt_hit;
    logic [VRAM_AW-1:0]  mapped_addr;

    assign nt_hit   = in_nametable(addr);
    assign addr_inc = addr + (inc32 ? 14'd32 : 14'd1);

    nt_mirror u_nt_mirror (
        .ppu_addr  (addr),
`ifdef PPU_VRAM_MIRROR_EN
        .mirror_h  (mirror_h),
`endif
        .vram_addr (mapped_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one ACCESS cycle per request, plus CAPTURE for nametable reads.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = ACCESS;
            ACCESS:  begin
                if (req_sel == SEL_DATA && req_rw && nt_hit) state_nxt = CAPTURE;
                else                                          state_nxt = IDLE;
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ack in ACCESS, VRAM strobes only for in-window PPUDATA.
    always_comb begin
        busy      = 1'b0;
        cpu_ack   = 1'b0;
        vram_en   = 1'b0;
        vram_rw   = 1'b0;
        vram_addr = '0;
        vram_din  = '0;
        case (state)
            ACCESS: begin
                busy    = 1'b1;
                cpu_ack = 1'b1;
                if (req_sel == SEL_DATA && nt_hit) begin
                    vram_en   = 1'b1;
                    vram_rw   = req_rw;
                    vram_addr = mapped_addr;
                    if (!req_rw) vram_din = req_din;
                end
            end
            CAPTURE: begin
                // Keep the read enabled so the gated VRAM data stays visible.
                busy      = 1'b1;
                vram_en   = 1'b1;
                vram_rw   = 1'b1;
                vram_addr = mapped_addr;
            end
            default: ;
        endcase
    end

    // Register-file state: request capture, address/latch/increment, read buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            w        <= 1'b0;
            inc32    <= 1'b0;
            rd_buf   <= 8'h00;
            cpu_dout <= 8'h00;
            req_sel  <= SEL_CTRL;
            req_rw   <= 1'b0;
            req_din  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_sel <= sel_t'(cpu_sel);
                        req_rw  <= cpu_rw;
                        req_din <= cpu_din;
                        // Read data is fixed at acceptance and held until the next read.
                        if (cpu_rw)
                            cpu_dout <= (sel_t'(cpu_sel) == SEL_DATA) ? rd_buf : 8'h00;
                    end
                end
                ACCESS: begin
                    case (req_sel)
                        SEL_CTRL:   if (!req_rw) inc32 <= req_din[2];
                        SEL_STATUS: if (req_rw) w <= 1'b0;
                        SEL_ADDR: begin
                            if (!req_rw) begin
                                if (!w) addr[13:8] <= req_din[5:0];
                                else    addr[7:0]  <= req_din;
                                w <= ~w;
                            end
                        end
                        SEL_DATA: begin
                            if (!req_rw) begin
                                addr <= addr_inc;
                            end else if (!nt_hit) begin
                                rd_buf <= 8'h00;
                                addr   <= addr_inc;
                            end
                        end
                        default: ;
                    endcase
                end
                CAPTURE: begin
                    rd_buf <= vram_dout;
                    addr   <= addr_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Self-checking bench for ppu_vram_port: a behavioural model predicts each
// access, pushes the expectation to a scoreboard, and a monitor compares on ack.
module tb_ppu_vram_port;
    import ppu_vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [1:0]  cpu_sel = 2'd0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        busy;
    logic        vram_en;
    logic        vram_rw;
    logic [10:0] vram_addr;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;
`ifdef PPU_VRAM_MIRROR_EN
    logic        mirror_h = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    ppu_vram_port u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_sel   (cpu_sel),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .busy      (busy),
`ifdef PPU_VRAM_MIRROR_EN
        .mirror_h  (mirror_h),
`endif
        .vram_en   (vram_en),
        .vram_rw   (vram_rw),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .vram_dout (vram_dout)
    );

    always #5 clk = ~clk;

    // 2 KB VRAM: synchronous read, data gated to 0 while disabled.
    logic [7:0] mem [0:2047];
    logic [7:0] vram_q;
    assign vram_dout = vram_en ? vram_q : 8'h00;
    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_rw) vram_q <= mem[vram_addr];
            else         mem[vram_addr] <= vram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [13:0] m_addr  = 14'h0000;
    logic        m_w     = 1'b0;
    logic        m_inc32 = 1'b0;
    logic [7:0]  m_rdbuf = 8'h00;
    logic [7:0]  m_mem [0:2047];

    typedef struct packed {
        logic        dout_chk;
        logic [7:0]  dout;
        logic        en;
        logic        rw;
        logic [10:0] va;
        logic [7:0]  vd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [10:0] map(input logic [13:0] a);
`ifdef PPU_VRAM_MIRROR_EN
        if (mirror_h) return {a[11], a[9:0]};
`endif
        return a[10:0];
    endfunction

    // Predict one access and push its expected ack-cycle view.
    task automatic model_push(input sel_t sel, input logic rw, input logic [7:0] din);
        exp_t        e;
        logic        nt;
        logic [10:0] va;
        e = '0;
        if (rw) e.dout_chk = 1'b1;
        case (sel)
            SEL_CTRL:   if (!rw) m_inc32 = din[2];
            SEL_STATUS: if (rw) m_w = 1'b0;
            SEL_ADDR: begin
                if (!rw) begin
                    if (!m_w) m_addr[13:8] = din[5:0];
                    else      m_addr[7:0]  = din;
                    m_w = ~m_w;
                end
            end
            SEL_DATA: begin
                nt   = (m_addr >= 14'h2000) && (m_addr <= 14'h3EFF);
                va   = map(m_addr);
                e.en = nt;
                e.rw = rw;
                e.va = va;
                e.vd = rw ? 8'h00 : din;
                if (rw) begin
                    e.dout  = m_rdbuf;
                    m_rdbuf = nt ? m_mem[va] : 8'h00;
                end else if (nt) begin
                    m_mem[va] = din;
                end
                m_addr = m_addr + (m_inc32 ? 14'd32 : 14'd1);
            end
            default: ;
        endcase
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 && busy; i++) @(negedge clk);
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_access(input sel_t sel, input logic rw, input logic [7:0] din);
        model_push(sel, rw, din);
        @(negedge clk);
        cpu_req = 1'b1; cpu_sel = sel; cpu_rw = rw; cpu_din = din;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_idle();
        check("ack_seen", sb.size(), 32'd0);
    endtask

    task automatic set_addr(input logic [13:0] a);
        do_access(SEL_ADDR, 1'b0, {2'b00, a[13:8]});
        do_access(SEL_ADDR, 1'b0, a[7:0]);
    endtask

    // Scoreboard monitor: compare the ACCESS-cycle view against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && cpu_ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", {31'd0, cpu_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("vram_en", {31'd0, vram_en}, {31'd0, mon_e.en});
                if (mon_e.en) begin
                    check("vram_rw", {31'd0, vram_rw}, {31'd0, mon_e.rw});
                    check("vram_addr", {21'd0, vram_addr}, {21'd0, mon_e.va});
                    if (!mon_e.rw) check("vram_din", {24'd0, vram_din}, {24'd0, mon_e.vd});
                end
                if (mon_e.dout_chk) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, mon_e.dout});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] a;
        logic [7:0]  d0, d1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_vram_en", {31'd0, vram_en}, 32'd0);
        check("rst_vram_addr", {21'd0, vram_addr}, 32'd0);
        check("rst_dout", {24'd0, cpu_dout}, 32'd0);
        check("rst_addr", {18'd0, u_dut.addr}, 32'd0);
        rst_n = 1'b1;

        // Address then write: 0x2108 <- 0x5A, then 0x2109 <- 0x33
        do_access(SEL_ADDR, 1'b0, 8'h21);
        do_access(SEL_ADDR, 1'b0, 8'h08);
        do_access(SEL_DATA, 1'b0, 8'h5A);
        check("addr_after_wr", {18'd0, u_dut.addr}, 32'h2109);
        do_access(SEL_DATA, 1'b0, 8'h33);

        // Buffered read
        set_addr(14'h2108);
        do_access(SEL_DATA, 1'b1, 8'h00);
        do_access(SEL_DATA, 1'b1, 8'h00);
        check("rd_buf", {24'd0, u_dut.rd_buf}, 32'h33);
        check("addr_after_rd", {18'd0, u_dut.addr}, {18'd0, m_addr});

        // Register reads return 0
        do_access(SEL_CTRL, 1'b1, 8'h00);
        do_access(SEL_ADDR, 1'b1, 8'h00);

        // Increment 32 and wrap
        do_access(SEL_CTRL, 1'b0, 8'h04);
        set_addr(14'h23E0);
        do_access(SEL_DATA, 1'b0, 8'hC3);
        check("addr_inc32", {18'd0, u_dut.addr}, 32'h2400);
        set_addr(14'h3FE0);
        do_access(SEL_DATA, 1'b0, 8'h99);
        check("addr_wrap", {18'd0, u_dut.addr}, 32'h0000);
        do_access(SEL_CTRL, 1'b0, 8'h00);

        // +1 wrap at top of address space
        set_addr(14'h3FFF);
        do_access(SEL_DATA, 1'b0, 8'h01);
        check("addr_wrap1", {18'd0, u_dut.addr}, 32'h0000);

        // Out-of-window read clears the buffer
        set_addr(14'h3F00);
        do_access(SEL_DATA, 1'b1, 8'h00);
        do_access(SEL_DATA, 1'b1, 8'h00);

        // Latch reset via PPUSTATUS
        do_access(SEL_ADDR, 1'b0, 8'h24);
        do_access(SEL_STATUS, 1'b1, 8'h00);
        do_access(SEL_ADDR, 1'b0, 8'h20);
        do_access(SEL_ADDR, 1'b0, 8'h00);
        check("addr_latch", {18'd0, u_dut.addr}, 32'h2000);

        // Write/readback sweep at random window addresses
        for (int i = 0; i < 6; i++) begin
            a  = 14'h2000 + 14'($urandom_range(0, 14'h1EF0));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            set_addr(a);
            do_access(SEL_DATA, 1'b0, d0);
            do_access(SEL_DATA, 1'b0, d1);
            set_addr(a);
            do_access(SEL_DATA, 1'b1, 8'h00);
            do_access(SEL_DATA, 1'b1, 8'h00);
            do_access(SEL_DATA, 1'b1, 8'h00);
        end

        // Request during CAPTURE is dropped
        set_addr(14'h2108);
        model_push(SEL_DATA, 1'b1, 8'h00);
        @(negedge clk);
        cpu_req = 1'b1; cpu_sel = SEL_DATA; cpu_rw = 1'b1; cpu_din = 8'h00;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("capture_busy", {31'd0, busy}, 32'd1);
        cpu_req = 1'b1; cpu_sel = SEL_ADDR; cpu_rw = 1'b0; cpu_din = 8'h3F;
        @(negedge clk);
        cpu_req = 1'b0;
        check("drop_ack", {31'd0, cpu_ack}, 32'd0);
        @(negedge clk);
        check("drop_ack2", {31'd0, cpu_ack}, 32'd0);
        check("drop_addr", {18'd0, u_dut.addr}, {18'd0, m_addr});
        check("drop_w", {31'd0, u_dut.w}, {31'd0, m_w});
        check("drop_rdbuf", {24'd0, u_dut.rd_buf}, {24'd0, m_rdbuf});
        check("drop_sb", sb.size(), 32'd0);

        // Reset during ACCESS
        set_addr(14'h2300);
        model_push(SEL_DATA, 1'b0, 8'hAB);
        @(negedge clk);
        cpu_req = 1'b1; cpu_sel = SEL_DATA; cpu_rw = 1'b0; cpu_din = 8'hAB;
        @(negedge clk);
        cpu_req = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_en", {31'd0, vram_en}, 32'd0);
        check("rst_mid_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_mid_addr", {18'd0, u_dut.addr}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst_n   = 1'b1;
        m_addr  = 14'h0000;
        m_w     = 1'b0;
        m_inc32 = 1'b0;
        m_rdbuf = 8'h00;

`ifdef PPU_VRAM_MIRROR_EN
        // Mirroring: both writes land on VRAM 0x400
        mirror_h = 1'b1;
        set_addr(14'h2800);
        do_access(SEL_DATA, 1'b0, 8'h11);
        mirror_h = 1'b0;
        set_addr(14'h2400);
        do_access(SEL_DATA, 1'b0, 8'h22);
`endif
        check("final_sb", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
